pc_fetch_unit: RTL and testbench

PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

---
 rtl/pc_fetch_unit_pkg.sv | 24 ++
 rtl/pc_fetch_unit_pc_next_sel.sv | 40 ++++
 rtl/pc_fetch_unit.sv | 124 ++++++++++++
 tb/tb_pc_fetch_unit.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/pc_fetch_unit_pkg.sv
// Shared types and constants for the PC / instruction fetch unit.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: FSM state enum, opcode field position, reset PC default,
// link register index, and the branch-offset helper.
package pc_fetch_unit_pkg;

   typedef enum logic {
      ST_FETCH = 1'b0,
      ST_EXEC  = 1'b1
   } fetch_state_e;

   localparam int unsigned      OPCODE_MSB       = 31;
   localparam int unsigned      OPCODE_LSB       = 26;
   localparam logic [31:0]      RESET_PC_DEFAULT = 32'h0000_0000;
   localparam logic [4:0]       LINK_REG_IDX     = 5'd31;

   // Word offset of a conditional branch: sign-extended imm16, scaled by 4.
   function automatic logic [31:0] branch_offset(input logic [15:0] imm16);
      return {{14{imm16[15]}}, imm16, 2'b00};
   endfunction

endpackage

// File: rtl/pc_fetch_unit_pc_next_sel.sv
// Combinational next-PC selection for the instruction being retired.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; result is only consumed when the top retires.
//
// Ports: pc_plus4 / instr_idx (instr[25:0]) / reg_target in, control
// strobes and flags in, next_pc out, link (link condition, ungated) out.
module pc_next_sel
   import pc_fetch_unit_pkg::*;
(
   input  logic [31:0] pc_plus4,
   input  logic [25:0] instr_idx,
   input  logic [31:0] reg_target,
   input  logic        branch,
   input  logic        baln,
   input  logic        jrsal,
   input  logic        jmnor,
   input  logic        zero,
   input  logic        nsignal,
   output logic [31:0] next_pc,
   output logic        link
);

   always_comb begin
      next_pc = pc_plus4;
      // Strict priority: register jumps, then taken baln, then taken beq.
      if (jrsal) begin
         next_pc = reg_target;
      end else if (jmnor) begin
         next_pc = reg_target;
      end else if (baln && nsignal) begin
         next_pc = {pc_plus4[31:28], instr_idx, 2'b00};
      end else if (branch && zero) begin
         next_pc = pc_plus4 + branch_offset(instr_idx[15:0]);
      end
   end

   // baln links only when actually taken; jrsal always links.
   assign link = jrsal | (baln & nsignal);

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register, two-state fetch/exec sequencer, instruction latch and status flags.
// Latency: instr valid the cycle after imem_ready; next fetch the cycle after advance.
// Backpressure: waits in FETCH for imem_ready and holds instr/pc in EXEC until advance.
//
// Ports: clk, rst_n; imem_req/imem_addr out, imem_ready/imem_rdata in;
// instr/opcode/instr_valid out; advance, control strobes, zero, alu_n,
// flag_we, reg_target in; pc, pc_plus4, link_we, nsignal_q, zsignal_q out.
module pc_fetch_unit
   import pc_fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr,
   output logic [5:0]  opcode,
   output logic        instr_valid,
   input  logic        advance,
   input  logic        branch,
   input  logic        baln,
   input  logic        jrsal,
   input  logic        jmnor,
   input  logic        zero,
   input  logic        alu_n,
   input  logic        flag_we,
   input  logic [31:0] reg_target,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic        link_we,
   output logic        nsignal_q,
   output logic        zsignal_q
);

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  instr_q, instr_d;
   logic         nsignal_d, zsignal_d;
   logic [31:0]  next_pc;
   logic         link_cond;

   assign pc        = pc_q;
   assign pc_plus4  = pc_q + 32'd4;
   assign imem_addr = pc_q;
   assign instr     = instr_q;
   assign opcode    = instr_q[OPCODE_MSB:OPCODE_LSB];

   pc_next_sel u_pc_next_sel (
      .pc_plus4   (pc_plus4),
      .instr_idx  (instr_q[25:0]),
      .reg_target (reg_target),
      .branch     (branch),
      .baln       (baln),
      .jrsal      (jrsal),
      .jmnor      (jmnor),
      .zero       (zero),
      .nsignal    (nsignal_q),
      .next_pc    (next_pc),
      .link       (link_cond)
   );

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_FETCH;
         pc_q      <= RESET_PC;
         instr_q   <= '0;
         nsignal_q <= 1'b0;
         zsignal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         instr_q   <= instr_d;
         nsignal_q <= nsignal_d;
         zsignal_q <= zsignal_d;
      end
   end

   // Next-state logic. next_pc reads nsignal_q before the flag update,
   // so a baln retiring with flag_we sees the old negative flag.
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      instr_d   = instr_q;
      nsignal_d = nsignal_q;
      zsignal_d = zsignal_q;
      unique case (state_q)
         ST_FETCH: begin
            if (imem_ready) begin
               instr_d = imem_rdata;
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            if (advance) begin
               pc_d    = next_pc;
               state_d = ST_FETCH;
               if (flag_we) begin
                  nsignal_d = alu_n;
                  zsignal_d = zero;
               end
            end
         end
         default: state_d = ST_FETCH;
      endcase
   end

   // Outputs. The state register already reads FETCH during reset, so the
   // request is also gated by rst_n to stay quiet while reset is held.
   always_comb begin
      imem_req    = 1'b0;
      instr_valid = 1'b0;
      link_we     = 1'b0;
      if (rst_n) begin
         imem_req    = (state_q == ST_FETCH);
         instr_valid = (state_q == ST_EXEC);
         link_we     = (state_q == ST_EXEC) && link_cond;
      end
   end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit with hand-computed expectations.
module tb_pc_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic [31:0] instr;
   logic [5:0]  opcode;
   logic        instr_valid;
   logic        advance;
   logic        branch, baln, jrsal, jmnor;
   logic        zero, alu_n, flag_we;
   logic [31:0] reg_target;
   logic [31:0] pc, pc_plus4;
   logic        link_we, nsignal_q, zsignal_q;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   pc_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ready (imem_ready),
      .imem_rdata (imem_rdata),
      .instr      (instr),
      .opcode     (opcode),
      .instr_valid(instr_valid),
      .advance    (advance),
      .branch     (branch),
      .baln       (baln),
      .jrsal      (jrsal),
      .jmnor      (jmnor),
      .zero       (zero),
      .alu_n      (alu_n),
      .flag_we    (flag_we),
      .reg_target (reg_target),
      .pc         (pc),
      .pc_plus4   (pc_plus4),
      .link_we    (link_we),
      .nsignal_q  (nsignal_q),
      .zsignal_q  (zsignal_q)
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic clear_ctl();
      advance = 0; branch = 0; baln = 0; jrsal = 0; jmnor = 0;
      zero = 0; alu_n = 0; flag_we = 0; reg_target = '0;
   endtask

   // Called at posedge+1 while in FETCH: returns word in one cycle.
   task automatic do_fetch(input logic [31:0] w);
      check("fetch_req", imem_req, 1);
      imem_ready = 1; imem_rdata = w;
      @(posedge clk); #1;
      imem_ready = 0; imem_rdata = '0;
      check("exec_valid", instr_valid, 1);
   endtask

   // Control strobes must be set by the caller; retires on the next edge.
   task automatic retire();
      advance = 1;
      @(posedge clk); #1;
      clear_ctl();
   endtask

   task automatic jump_to(input logic [31:0] addr);
      do_fetch(32'h0);
      jrsal = 1; reg_target = addr;
      retire();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 0; imem_ready = 0; imem_rdata = '0;
      clear_ctl();
      #1;
      // Reset state
      check("rst_req", imem_req, 0);
      check("rst_valid", instr_valid, 0);
      check("rst_link", link_we, 0);
      check("rst_pc", pc, 32'h0);
      check("rst_instr", instr, 32'h0);
      check("rst_n_flag", nsignal_q, 0);
      check("rst_z_flag", zsignal_q, 0);

      repeat (2) @(posedge clk);
      @(negedge clk); rst_n = 1;
      #1;
      check("rel_req", imem_req, 1);
      check("rel_addr", imem_addr, 32'h0);

      // Memory answers after 3 cycles
      repeat (3) begin
         @(posedge clk); #1;
         check("wait_valid", instr_valid, 0);
      end
      check("wait_addr", imem_addr, 32'h0);
      do_fetch(32'h8C22_0004);
      check("lw_opcode", opcode, 6'h23);
      check("lw_instr", instr, 32'h8C22_0004);
      check("exec_noreq", imem_req, 0);

      // Hold in EXEC; imem_ready ignored there
      imem_ready = 1; imem_rdata = 32'hDEAD_BEEF;
      @(posedge clk); #1;
      imem_ready = 0; imem_rdata = '0;
      check("hold_instr", instr, 32'h8C22_0004);
      check("hold_valid", instr_valid, 1);
      check("hold_pc", pc, 32'h0);

      // jrsal to 0x40, then beq taken
      jrsal = 1; reg_target = 32'h40; #1;
      check("jrsal_link", link_we, 1);
      retire();
      check("jr_pc", pc, 32'h40);
      check("jr_req", imem_req, 1);
      do_fetch(32'h1000_0003);
      branch = 1; zero = 1;
      retire();
      check("beq_taken", imem_addr, 32'h50);

      // beq not taken
      jump_to(32'h40);
      do_fetch(32'h1000_0003);
      branch = 1; zero = 0; #1;
      check("beq_nolink", link_we, 0);
      retire();
      check("beq_fall", imem_addr, 32'h44);

      // Backward branch: 0x48 + (-4)
      do_fetch(32'h1000_FFFF);
      branch = 1; zero = 1;
      retire();
      check("beq_back", pc, 32'h44);

      // Set N flag on a retiring jrsal to 0x80
      do_fetch(32'h0);
      jrsal = 1; reg_target = 32'h80; flag_we = 1; alu_n = 1; zero = 0;
      retire();
      check("flag_n_set", nsignal_q, 1);
      check("flag_z_clr", zsignal_q, 0);

      // baln taken, using pre-update N while flags overwrite
      do_fetch(32'h4C00_0100);
      baln = 1; flag_we = 1; alu_n = 0; zero = 1; #1;
      check("baln_link", link_we, 1);
      check("baln_pc4", pc_plus4, 32'h84);
      retire();
      check("baln_pc", pc, 32'h400);
      check("flag_n_upd", nsignal_q, 0);
      check("flag_z_upd", zsignal_q, 1);

      // baln not taken with N=0
      jump_to(32'h80);
      check("flag_hold", zsignal_q, 1);
      do_fetch(32'h4C00_0100);
      baln = 1; #1;
      check("baln_nt_link", link_we, 0);
      retire();
      check("baln_nt_pc", pc, 32'h84);

      // jrsal beats a taken branch
      do_fetch(32'h1000_0003);
      jrsal = 1; reg_target = 32'h1234; branch = 1; zero = 1; #1;
      check("prio_link", link_we, 1);
      retire();
      check("prio_pc", pc, 32'h1234);

      // jmnor beats baln; no link
      do_fetch(32'h4C00_0100);
      jmnor = 1; baln = 1; reg_target = 32'hFFFF_FFFC; #1;
      check("jmnor_link", link_we, 0);
      retire();
      check("jmnor_pc", pc, 32'hFFFF_FFFC);

      // Wrap at top of address space
      check("wrap_pc4", pc_plus4, 32'h0);
      do_fetch(32'hAAAA_0000);
      retire();
      check("wrap_pc", pc, 32'h0);

      // advance ignored in FETCH
      advance = 1;
      @(posedge clk); #1;
      advance = 0;
      check("adv_fetch_pc", pc, 32'h0);
      check("adv_fetch_req", imem_req, 1);

      // Move to 0x200 with both flags set, then reset mid-fetch
      do_fetch(32'hAAAA_0000);
      jrsal = 1; reg_target = 32'h200; flag_we = 1; alu_n = 1; zero = 1;
      retire();
      check("pre_rst_pc", pc, 32'h200);
      imem_ready = 1; imem_rdata = 32'hDEAD_BEEF;
      rst_n = 0; #1;
      check("mid_rst_req", imem_req, 0);
      check("mid_rst_pc", pc, 32'h0);
      @(posedge clk); #1;
      check("mid_rst_instr", instr, 32'h0);
      check("mid_rst_valid", instr_valid, 0);
      check("mid_rst_n", nsignal_q, 0);
      check("mid_rst_z", zsignal_q, 0);
      imem_ready = 0; imem_rdata = '0;
      @(negedge clk); rst_n = 1; #1;
      check("rerel_req", imem_req, 1);
      check("rerel_addr", imem_addr, 32'h0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
